// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between execute-stage requesters/decode and regfile_wb_arbiter.
// Groups the requester handshakes, the decode allocation/query port and the
// registered register-file write port. When RFWB_FWD_EN is defined the bus
// also carries the forwarding hit flags fwd_A/fwd_B.
interface regfile_wb_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int DW    = 32
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [5*N_REQ-1:0]  req_reg;
  logic [DW*N_REQ-1:0] req_data;
  logic                alloc_valid;
  logic [4:0]          alloc_reg;
  logic                alloc_ready;
  logic [4:0]          regA;
  logic [4:0]          regB;
  logic                busy_A;
  logic                busy_B;
  logic                RegWrite;
  logic [4:0]          regW;
  logic [DW-1:0]       Wdat;
  logic                err;
`ifdef RFWB_FWD_EN
  logic                fwd_A;
  logic                fwd_B;
`endif

  // Execute units and decode drive requests and queries.
  modport master (
    output req_valid, req_reg, req_data, alloc_valid, alloc_reg, regA, regB,
`ifdef RFWB_FWD_EN
    input  fwd_A, fwd_B,
`endif
    input  req_ready, alloc_ready, busy_A, busy_B, RegWrite, regW, Wdat, err
  );

  // The arbiter answers them and drives the register-file write port.
  modport slave (
    input  req_valid, req_reg, req_data, alloc_valid, alloc_reg, regA, regB,
`ifdef RFWB_FWD_EN
    output fwd_A, fwd_B,
`endif
    output req_ready, alloc_ready, busy_A, busy_B, RegWrite, regW, Wdat, err
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter for the single register-file write
// port plus a 32-entry busy scoreboard used by decode for operand stalls.
// Optional feature macro: RFWB_FWD_EN adds fwd_A/fwd_B and masks busy_A/B
// during the RegWrite cycle so decode can take the operand from Wdat.
module regfile_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 Rst_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    rrPtr;
  logic [PW-1:0]    nextPtr;
  logic [N_REQ-1:0] grant;
  logic             transfer;
  logic [4:0]       selReg;
  logic [DW-1:0]    selData;
  logic [31:0]      busyQ;
  logic [31:0]      busyNext;
  logic             allocReady;
  logic             allocFire;
  logic             errSet;
  logic             regWriteQ;
  logic [4:0]       regWQ;
  logic [DW-1:0]    wdatQ;
  logic             errQ;
  logic             fwdA;
  logic             fwdB;

  // Round-robin search starting at rrPtr; picks the first valid requester.
  always_comb begin
    int   idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    grant   = '0;
    selReg  = 5'd0;
    selData = '0;
    nextPtr = rrPtr;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rrPtr) + k) % N_REQ;
      if (!found && bus.req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        selReg     = bus.req_reg[5*idx +: 5];
        selData    = bus.req_data[DW*idx +: DW];
        nextPtr    = PW'((idx + 1) % N_REQ);
      end else begin
        found = found;
      end
    end
  end

  assign transfer      = |grant;
  assign bus.req_ready = grant;

  // Decode may claim a register only when it has no producer in flight.
  assign allocReady      = ~busyQ[bus.alloc_reg] | (bus.alloc_reg == 5'd0);
  assign allocFire       = bus.alloc_valid & allocReady & (bus.alloc_reg != 5'd0);
  assign bus.alloc_ready = allocReady;

  // A write to a register that nobody allocated is a protocol error.
  assign errSet = transfer & (selReg != 5'd0) & ~busyQ[selReg];

  // Scoreboard next state: clear on the committing edge, then alloc so a new producer wins.
  always_comb begin
    busyNext = busyQ;
    if (regWriteQ) begin
      busyNext[regWQ] = 1'b0;
    end else begin
      busyNext = busyNext;
    end
    if (allocFire) begin
      busyNext[bus.alloc_reg] = 1'b1;
    end else begin
      busyNext = busyNext;
    end
    busyNext[0] = 1'b0;
  end

  // Scoreboard, round-robin pointer and sticky error flag.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      busyQ <= 32'd0;
      rrPtr <= '0;
      errQ  <= 1'b0;
    end else begin
      busyQ <= busyNext;
      rrPtr <= nextPtr;
      errQ  <= errQ | errSet;
    end
  end

  // Registered register-file write port; address/data hold when idle.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      regWriteQ <= 1'b0;
      regWQ     <= 5'd0;
      wdatQ     <= '0;
    end else if (transfer) begin
      regWriteQ <= (selReg != 5'd0);
      regWQ     <= selReg;
      wdatQ     <= selData;
    end else begin
      regWriteQ <= 1'b0;
    end
  end

  assign bus.RegWrite = regWriteQ;
  assign bus.regW     = regWQ;
  assign bus.Wdat     = wdatQ;
  assign bus.err      = errQ;

  assign fwdA = regWriteQ & (regWQ == bus.regA) & (bus.regA != 5'd0);
  assign fwdB = regWriteQ & (regWQ == bus.regB) & (bus.regB != 5'd0);

`ifdef RFWB_FWD_EN
  assign bus.fwd_A  = fwdA;
  assign bus.fwd_B  = fwdB;
  assign bus.busy_A = busyQ[bus.regA] & ~fwdA;
  assign bus.busy_B = busyQ[bus.regB] & ~fwdB;
`else
  // Without forwarding the operand stays busy until the clearing edge.
  assign bus.busy_A = busyQ[bus.regA] | (fwdA & 1'b0);
  assign bus.busy_B = busyQ[bus.regB] | (fwdB & 1'b0);
`endif
endmodule
